// File: rtl/uart_frame_rx.sv
// UART byte receiver with sync-delimited 64-bit frame assembly.
// Defining UART_FRAME_CHKSUM_EN adds a trailing XOR checksum byte that each frame must match.
module uart_frame_rx #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD         = 115200,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned FRAME_BYTES  = 8,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        rx_pin_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic [63:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TMO_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMO_W        = $clog2(TMO_CLKS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] F_HUNT    = 2'd0;
    localparam logic [1:0] F_COLLECT = 2'd1;
`ifdef UART_FRAME_CHKSUM_EN
    localparam logic [1:0] F_CHECK   = 2'd2;
`endif

    logic             r_sync1, r_sync2, r_sync3;
    logic             w_fall;
    logic [1:0]       r_bit_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_bit_ferr;

    logic [1:0]       r_fr_state;
    logic [3:0]       r_idx;
    logic [63:0]      r_buf;
    logic [63:0]      w_buf_next;
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_hit;
    logic [63:0]      r_frame_data;
    logic             r_frame_valid;
    logic             r_frame_err;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]       r_xor;
`endif

    assign w_fall      = r_sync3 & ~r_sync2;
    assign busy        = (r_bit_state != S_IDLE);
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync3     <= 1'b1;
            r_bit_state <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_bit_ferr  <= 1'b0;
        end else begin
            r_sync1    <= rx_pin_in;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_rx_valid <= 1'b0;
            r_bit_ferr <= 1'b0;
            case (r_bit_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_bit_state <= S_START;
                        r_bit_cnt   <= CNT_W'(HALF_BIT);
                    end
                end
                S_START: begin
                    if (r_bit_cnt == '0) begin
                        if (r_sync2) begin
                            r_bit_state <= S_IDLE;
                        end else begin
                            r_bit_state <= S_DATA;
                            r_bit_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                            r_bit_idx   <= '0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_bit_cnt == '0) begin
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                        if (r_bit_idx == 3'd7) r_bit_state <= S_STOP;
                        else                   r_bit_idx   <= r_bit_idx + 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                default: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (r_bit_cnt == '0) begin
                        if (r_sync2) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_bit_ferr <= 1'b1;
                        end
                        r_bit_state <= S_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_buf_next = r_buf;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r_idx == 4'(i)) w_buf_next[8*(7-i) +: 8] = r_rx_data;
        end
    end

    assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CLKS - 1)) && !busy;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_fr_state    <= F_HUNT;
            r_idx         <= '0;
            r_buf         <= '0;
            r_tmo         <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            r_xor         <= '0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_fr_state)
                F_COLLECT: begin
                    // A received byte outranks a timeout expiring in the same cycle.
                    if (r_bit_ferr) begin
                        r_frame_err <= 1'b1;
                        r_fr_state  <= F_HUNT;
                    end else if (r_rx_valid) begin
                        r_tmo <= '0;
                        r_buf <= w_buf_next;
                        r_idx <= r_idx + 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
                        r_xor <= r_xor ^ r_rx_data;
                        if (r_idx == 4'(FRAME_BYTES - 1)) r_fr_state <= F_CHECK;
`else
                        if (r_idx == 4'(FRAME_BYTES - 1)) begin
                            r_frame_data  <= w_buf_next;
                            r_frame_valid <= 1'b1;
                            r_fr_state    <= F_HUNT;
                        end
`endif
                    end else if (w_tmo_hit) begin
                        r_frame_err <= 1'b1;
                        r_fr_state  <= F_HUNT;
                    end else if (!busy) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
`ifdef UART_FRAME_CHKSUM_EN
                F_CHECK: begin
                    if (r_bit_ferr) begin
                        r_frame_err <= 1'b1;
                        r_fr_state  <= F_HUNT;
                    end else if (r_rx_valid) begin
                        if (r_rx_data == r_xor) begin
                            r_frame_data  <= r_buf;
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_fr_state <= F_HUNT;
                    end else if (w_tmo_hit) begin
                        r_frame_err <= 1'b1;
                        r_fr_state  <= F_HUNT;
                    end else if (!busy) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
`endif
                default: begin
                    r_tmo <= '0;
                    if (r_bit_ferr) begin
                        r_frame_err <= 1'b1;
                    end else if (r_rx_valid && (r_rx_data == SYNC_BYTE)) begin
                        r_fr_state <= F_COLLECT;
                        r_idx      <= '0;
                        r_buf      <= '0;
`ifdef UART_FRAME_CHKSUM_EN
                        r_xor      <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomised self-checking bench for uart_frame_rx against a queue-based frame model.
module tb_uart_frame_rx;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;
    localparam int unsigned FB       = 8;
    localparam int unsigned TB       = 20;
    localparam logic [7:0]  SYNC     = 8'hA5;
`ifdef UART_FRAME_CHKSUM_EN
    localparam int unsigned EMB_NRX  = 10;
`else
    localparam int unsigned EMB_NRX  = 9;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .SYNC_BYTE(SYNC),
        .FRAME_BYTES(FB),
        .TIMEOUT_BITS(TB)
    ) dut (
        .CLK100MHZ(clk),
        .reset(rst),
        .rx_pin_in(rxd),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observed activity
    logic [7:0]  a_rx[$];
    logic [63:0] a_fr[$];
    int          a_err = 0;
    int          cyc = 0;
    int          last_rx_cyc = 0;
    int          err_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            a_rx.push_back(rx_data);
            last_rx_cyc = cyc;
        end
        if (frame_valid) a_fr.push_back(frame_data);
        if (frame_err) begin
            a_err++;
            err_cyc = cyc;
        end
        if (frame_valid || frame_err)
            check("valid_err_excl", {63'd0, frame_valid & frame_err}, 64'd0);
    end

    // Reference model: bytes in, expected bytes/frames/errors out
    logic [7:0]  m_rx[$];
    logic [63:0] m_fr[$];
    logic [7:0]  m_pay[$];
    int          m_err = 0;
    bit          m_hunt = 1'b1;
    logic [7:0]  m_last = '0;
    logic [63:0] m_frame = '0;

    function automatic logic [63:0] pack_payload();
        logic [63:0] w = '0;
        for (int i = 0; i < m_pay.size(); i++)
            w = w | (64'(m_pay[i]) << (8 * (7 - i)));
        return w;
    endfunction

    function automatic logic [7:0] xor_of(input logic [63:0] w);
        logic [7:0] x = '0;
        for (int i = 0; i < int'(FB); i++) x = x ^ w[63-8*i -: 8];
        return x;
    endfunction

    task automatic m_good(input logic [7:0] b);
        m_rx.push_back(b);
        m_last = b;
        if (m_hunt) begin
            if (b == SYNC) begin
                m_hunt = 1'b0;
                m_pay.delete();
            end
        end else if (m_pay.size() < int'(FB)) begin
            m_pay.push_back(b);
`ifndef UART_FRAME_CHKSUM_EN
            if (m_pay.size() == int'(FB)) begin
                m_frame = pack_payload();
                m_fr.push_back(m_frame);
                m_hunt = 1'b1;
            end
`endif
        end else begin
            if (b == xor_of(pack_payload())) begin
                m_frame = pack_payload();
                m_fr.push_back(m_frame);
            end else begin
                m_err++;
            end
            m_hunt = 1'b1;
        end
    endtask

    task automatic m_timeout();
        if (!m_hunt) begin
            m_err++;
            m_hunt = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (gap_bits * CPB) @(negedge clk);
        if (stop_ok) m_good(b);
        else begin
            m_err++;
            m_hunt = 1'b1;
        end
    endtask

    task automatic send_payload(input logic [63:0] w, input int gap_max);
        send_byte(SYNC, 1'b1, $urandom_range(gap_max, 0));
        for (int i = 0; i < int'(FB); i++)
            send_byte(w[63-8*i -: 8], 1'b1, $urandom_range(gap_max, 0));
    endtask

    task automatic send_frame(input logic [63:0] w, input int gap_max);
        send_payload(w, gap_max);
`ifdef UART_FRAME_CHKSUM_EN
        send_byte(xor_of(w), 1'b1, $urandom_range(gap_max, 0));
`endif
    endtask

    task automatic compare(input string tag);
        repeat (2 * CPB) @(negedge clk);
        check($sformatf("%s_nrx", tag), 64'(a_rx.size()), 64'(m_rx.size()));
        for (int i = 0; i < a_rx.size() && i < m_rx.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), 64'(a_rx[i]), 64'(m_rx[i]));
        check($sformatf("%s_nfr", tag), 64'(a_fr.size()), 64'(m_fr.size()));
        for (int i = 0; i < a_fr.size() && i < m_fr.size(); i++)
            check($sformatf("%s_fr%0d", tag, i), a_fr[i], m_fr[i]);
        check($sformatf("%s_nerr", tag), 64'(a_err), 64'(m_err));
        check($sformatf("%s_rx_data", tag), 64'(rx_data), 64'(m_last));
        check($sformatf("%s_frame_data", tag), frame_data, m_frame);
        a_rx.delete(); m_rx.delete();
        a_fr.delete(); m_fr.delete();
        a_err = 0; m_err = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, 64'(rx_data), 64'd0);
        check({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
        check({tag, "_frame_data"}, frame_data, 64'd0);
        check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        logic [63:0] w;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte
        send_byte(8'h3C, 1'b1, 2);
        check("single_busy", 64'(busy), 64'd0);
        check("single_rx_data", 64'(rx_data), 64'h3C);
        compare("single");

        // Known frame
        send_frame(64'h0123456789ABCDEF, 1);
        repeat (2) @(negedge clk);
        check("known_frame", frame_data, 64'h0123456789ABCDEF);
        compare("known");
`ifdef UART_FRAME_CHKSUM_EN
        send_payload(64'h0123456789ABCDEE, 1);
        send_byte(8'h00, 1'b1, 2);
        check("badchk_keep", frame_data, 64'h0123456789ABCDEF);
        compare("badchk");
`endif

        // Short glitch on idle line
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_busy", 64'(busy), 64'd0);
        compare("glitch");

        // Stop bit held low
        send_byte(8'h3C, 1'b0, 2);
        compare("badstop");

        // Inter-byte timeout inside a frame
        send_byte(SYNC, 1'b1, 0);
        send_byte(8'h11, 1'b1, 0);
        err_cyc = 0;
        send_byte(8'h22, 1'b1, 25);
        m_timeout();
        lat = err_cyc - last_rx_cyc;
        check("tmo_lat", 64'((lat >= int'(TB * CPB)) && (lat <= int'(TB * CPB) + 2)), 64'd1);
        send_frame({$urandom, $urandom}, 2);
        compare("timeout");

        // Reset in the middle of the 4th payload byte
        send_byte(SYNC, 1'b1, 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 0);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m_hunt = 1'b1;
        m_pay.delete();
        m_last = '0;
        m_frame = '0;
        repeat (2) @(negedge clk);
        send_frame({$urandom, $urandom}, 1);
        compare("midreset");

        // Embedded sync, back-to-back
        send_frame(64'hA5A5A5A5A5A5A5A5, 0);
        repeat (2 * CPB) @(negedge clk);
        check("emb_nrx", 64'(a_rx.size()), 64'(EMB_NRX));
        check("emb_frame", frame_data, 64'hA5A5A5A5A5A5A5A5);
        compare("emb");

        // Random frames with optional junk before the sync byte
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == SYNC) j = 8'h5A;
                send_byte(j, 1'b1, $urandom_range(2, 0));
            end
            w = {$urandom, $urandom};
            send_frame(w, 2);
        end
        compare("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
